mux7seg_n: RTL
==============

# mux7seg_n

Parametrised multiplexed seven-segment display driver. It scans `DIGITS` common-cathode digits from a packed hex word, with per-digit decimal points, optional leading-zero blanking, and 16-level PWM brightness. Loads are double-buffered and take effect only at a frame boundary, so the display never tears. It sits between the datapath result registers, such as the adder/subtractor output, and the board's SEG/DP/CAT pins, replacing the fixed 4-digit driver.

## Interface
Parameters:
- `DIGITS`, default 4: number of digits scanned, legal range 1..8.
- `REFRESH_DIV`, default 100000: clock cycles per digit slot, ≥ 2.

Ports:
- `Clock`  in  1: system clock; the only clock.
- `Reset`  in  1: asynchronous, active-low reset.
- `Load`  in  1: synchronous one-cycle strobe; captures `HexIN`/`DpIN`.
- `HexIN`  in  4*DIGITS: nibble i drives digit i; digit 0 is the rightmost.
- `DpIN`  in  DIGITS: bit i is 1 to light DP on digit i.
- `BlankLZ`  in  1: 1 enables leading-zero blanking.
- `Bright`  in  4: brightness; 0 is dimmest, 15 is full on.
- `SEG`  out  [0:6]: segments a..g, active-low.
- `DP`  out  1: decimal point, active-low.
- `CAT`  out  DIGITS: digit enables, active-low, at most one low at a time.
- `FrameStart`  out  1: one-cycle pulse when the scan returns to digit 0.

## Operation
- **Prescaler.** Counts 0..REFRESH_DIV-1 and wraps. `tick` is asserted while the count equals REFRESH_DIV-1.
- **Digit index.** 0..DIGITS-1, advances on `tick`, and wraps from DIGITS-1 to 0. The wrap is the frame boundary, `wrap = tick && idx==DIGITS-1`.
- **PWM counter.** 4-bit, free-running, increments every clock. The selected digit is enabled when `pwm <= Bright`, giving a duty of (Bright+1)/16.
- **Buffering.** Three registers hold loaded data:
  - The shadow register and `pending` flag. `Load` writes `HexIN`/`DpIN` into shadow and sets `pending`. A later `Load` before transfer overwrites the shadow; last load wins.
  - The display register. On `wrap` with `pending`=1, display ← shadow and `pending` clears.
  - Coincident `Load` and `wrap`: display ← `HexIN`/`DpIN` directly, shadow ← the same values, and `pending`=0.
- **Leading-zero blanking.** With `BlankLZ`=1, digit i (i ≥ 1) is blanked when nibbles i..DIGITS-1 are all 0 and DP bits i..DIGITS-1 are all 0. Digit 0 is never blanked.
- **Blanked slot.** `CAT` is all ones and `SEG`/`DP` are all ones for the whole slot.
- **Decode, active-low a..g:**
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- **CAT.** Bit idx is low when the digit is enabled and not blanked; all other bits are high.
- **FrameStart.** Pulses high for one cycle when `idx` becomes 0.

## Timing
- `SEG`, `DP`, `CAT` and `FrameStart` are registered. They reflect `idx`, `pwm` and the display register from the previous cycle, a one-clock output latency.
- Slot length is exactly REFRESH_DIV cycles; frame length is DIGITS*REFRESH_DIV cycles.
- A `Load` in cycle t is visible on the outputs no earlier than the first digit-0 slot after the next `wrap`. The worst case is one full frame plus 1 cycle.
- Reset (`Reset`=0) acts immediately, with no clock required. It sets:
  - `SEG`=1111111, `DP`=1, `CAT`=all ones, `FrameStart`=0
  - `idx`=0, prescaler=0, `pwm`=0
  - shadow=0, display=0, `pending`=0
- After `Reset` rises, the first `wrap` occurs at cycle DIGITS*REFRESH_DIV-1.
- Reset asserted mid-frame or mid-load discards the pending data.
- Inputs are sampled only on the `Clock` rising edge. `Bright` and `BlankLZ` changes take effect on the next cycle, with no buffering.
- With `DIGITS`=1, `wrap` = `tick`, and `CAT` is 1 bit.

## Test plan
All scenarios use DIGITS=4 and REFRESH_DIV=4 unless stated otherwise.
- **Reset values.** Reset low mid-scan with `Bright`=15 → `CAT`=1111, `SEG`=1111111 and `DP`=1 immediately. After release the scan starts, and every digit shows 0000001 once running.
- **Scan order.** `Load` `HexIN`=0x12AF, `DpIN`=0100, `Bright`=15 → after the next `FrameStart`:
  - `CAT` steps 1110/0111000, 1101/0001000, 1011/0010010 with `DP`=0, then 0111/1001111.
  - Each step lasts 4 cycles.
- **Tear-free update.** Load 0x1111, then `Load` 0x2222 two cycles after a `FrameStart` → the rest of the frame still shows 1001111. 0010010 appears only after the next `FrameStart`.
- **Coincident load and wrap.** `Load` 0x3333 in the `wrap` cycle → the following frame shows 0000110 and `pending`=0. A second, later `Load` 0x4444 in the same frame is deferred to the next frame.
- **Leading-zero blanking.** `BlankLZ`=1 with 0x0050 → digit 3 and digit 2 slots show `CAT`=1111; digit 1 shows 0100100 and digit 0 shows 0000001.
  - 0x0000 → only digit 0 is lit.
  - 0x0000 with `DpIN`=0100 → digits 2..0 are lit.
- **Brightness.** REFRESH_DIV=16, `Bright`=3 → in each slot `CAT` is low for exactly 4 consecutive cycles, then high for 12. `Bright`=15 → low all 16 cycles.

Source files
------------

// File: rtl/mux7seg_n.sv
// Multiplexed seven-segment driver: scans DIGITS common-cathode digits with
// double-buffered loads, leading-zero blanking and 16-level PWM brightness.
module mux7seg_n #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   HexIN,
  input  logic [DIGITS-1:0]     DpIN,
  input  logic                  BlankLZ,
  input  logic [3:0]            Bright,
  output logic [0:6]            SEG,
  output logic                  DP,
  output logic [DIGITS-1:0]     CAT,
  output logic                  FrameStart
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  function automatic logic [0:6] decode7(input logic [3:0] nib);
    case (nib)
      4'h0:    decode7 = 7'b0000001;
      4'h1:    decode7 = 7'b1001111;
      4'h2:    decode7 = 7'b0010010;
      4'h3:    decode7 = 7'b0000110;
      4'h4:    decode7 = 7'b1001100;
      4'h5:    decode7 = 7'b0100100;
      4'h6:    decode7 = 7'b0100000;
      4'h7:    decode7 = 7'b0001111;
      4'h8:    decode7 = 7'b0000000;
      4'h9:    decode7 = 7'b0000100;
      4'hA:    decode7 = 7'b0001000;
      4'hB:    decode7 = 7'b1100000;
      4'hC:    decode7 = 7'b0110001;
      4'hD:    decode7 = 7'b1000010;
      4'hE:    decode7 = 7'b0110000;
      4'hF:    decode7 = 7'b0111000;
      default: decode7 = 7'b1111111;
    endcase
  endfunction

  logic [PW-1:0]       presc_r;
  logic [IW-1:0]       idx_r;
  logic [3:0]          pwm_r;
  logic                wrap_q_r;
  logic [4*DIGITS-1:0] shadow_hex_r;
  logic [DIGITS-1:0]   shadow_dp_r;
  logic                pending_r;
  logic [4*DIGITS-1:0] disp_hex_r;
  logic [DIGITS-1:0]   disp_dp_r;
  logic [0:6]          seg_r;
  logic                dp_r;
  logic [DIGITS-1:0]   cat_r;
  logic                frame_start_r;

  logic                tick_s;
  logic                wrap_s;
  logic [3:0]          nib_s;
  logic                dp_sel_s;
  logic                blank_s;
  logic                lz_run_s;
  logic                on_s;
  logic [DIGITS-1:0]   cat_s;

  assign tick_s = (presc_r == PRESC_LAST);
  assign wrap_s = tick_s && (idx_r == IDX_LAST);

  // Select the current digit; lz_run_s tracks "everything from here upward is zero"
  always_comb begin
    nib_s    = 4'h0;
    dp_sel_s = 1'b0;
    blank_s  = 1'b0;
    lz_run_s = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_run_s = lz_run_s && (disp_hex_r[4*i +: 4] == 4'h0) && !disp_dp_r[i];
      nib_s    = (idx_r == IW'(i)) ? disp_hex_r[4*i +: 4] : nib_s;
      dp_sel_s = (idx_r == IW'(i)) ? disp_dp_r[i] : dp_sel_s;
      blank_s  = (idx_r == IW'(i)) ? (BlankLZ && (i != 0) && lz_run_s) : blank_s;
    end
    on_s  = (pwm_r <= Bright) && !blank_s;
    cat_s = '1;
    for (int i = 0; i < DIGITS; i++) begin
      cat_s[i] = !(on_s && (idx_r == IW'(i)));
    end
  end

  // Scan timing: slot prescaler, digit index, PWM phase
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      presc_r  <= '0;
      idx_r    <= '0;
      pwm_r    <= 4'd0;
      wrap_q_r <= 1'b0;
    end else begin
      presc_r  <= tick_s ? '0 : presc_r + PW'(1);
      if (tick_s) begin
        idx_r <= (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
      end else begin
        idx_r <= idx_r;
      end
      pwm_r    <= pwm_r + 4'd1;
      wrap_q_r <= wrap_s;
    end
  end

  // Double buffer: a load coinciding with the frame boundary bypasses the shadow
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      shadow_hex_r <= '0;
      shadow_dp_r  <= '0;
      pending_r    <= 1'b0;
      disp_hex_r   <= '0;
      disp_dp_r    <= '0;
    end else if (Load && wrap_s) begin
      shadow_hex_r <= HexIN;
      shadow_dp_r  <= DpIN;
      disp_hex_r   <= HexIN;
      disp_dp_r    <= DpIN;
      pending_r    <= 1'b0;
    end else if (Load) begin
      shadow_hex_r <= HexIN;
      shadow_dp_r  <= DpIN;
      pending_r    <= 1'b1;
    end else if (wrap_s && pending_r) begin
      disp_hex_r   <= shadow_hex_r;
      disp_dp_r    <= shadow_dp_r;
      pending_r    <= 1'b0;
    end else begin
      pending_r    <= pending_r;
    end
  end

  // Output registers; FrameStart is delayed so it lines up with digit 0 on the pins
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      seg_r         <= 7'b1111111;
      dp_r          <= 1'b1;
      cat_r         <= '1;
      frame_start_r <= 1'b0;
    end else begin
      seg_r         <= blank_s ? 7'b1111111 : decode7(nib_s);
      dp_r          <= blank_s ? 1'b1 : !dp_sel_s;
      cat_r         <= cat_s;
      frame_start_r <= wrap_q_r;
    end
  end

  assign SEG        = seg_r;
  assign DP         = dp_r;
  assign CAT        = cat_r;
  assign FrameStart = frame_start_r;

endmodule
